// File: rtl/riscv32ima_pkg.sv
// Shared constants for the riscv32ima core: GPRF geometry and writeback requester ids.
// Latency: none (declarations only).
// Backpressure: n/a.
package riscv32ima_pkg;

  localparam int REG_ADDR_WIDTH = 5;
  localparam int REG_DATA_WIDTH = 32;
  localparam int NUM_REGS       = 2 ** REG_ADDR_WIDTH;

  // Writeback requesters; the index is also the bit position in req_valid/req_ready.
  localparam int NUM_WB_REQ = 3;
  localparam int REQ_ALU    = 0;
  localparam int REQ_LSU    = 1;
  localparam int REQ_MDU    = 2;

endpackage

// File: rtl/riscv32ima_rr_arb3.sv
// Three-way round-robin arbiter with a pointer that moves past the last winner.
// Latency: grant is combinational from req_valid; the pointer updates on the granting edge.
// Backpressure: a requester keeps valid until granted; the grant never depends on a future cycle.
module riscv32ima_rr_arb3
  import riscv32ima_pkg::*;
(
  input  logic       clk,
  input  logic       nrst,
  input  logic [2:0] req_valid,
  output logic [2:0] grant
);

  logic [1:0] ptr;
  logic [1:0] ptr_nxt;

  // First valid requester at or after the pointer, scanning upward with wrap.
  always_comb begin
    grant = 3'b000;
    case (ptr)
      2'd0: begin
        if      (req_valid[REQ_ALU]) grant[REQ_ALU] = 1'b1;
        else if (req_valid[REQ_LSU]) grant[REQ_LSU] = 1'b1;
        else if (req_valid[REQ_MDU]) grant[REQ_MDU] = 1'b1;
      end
      2'd1: begin
        if      (req_valid[REQ_LSU]) grant[REQ_LSU] = 1'b1;
        else if (req_valid[REQ_MDU]) grant[REQ_MDU] = 1'b1;
        else if (req_valid[REQ_ALU]) grant[REQ_ALU] = 1'b1;
      end
      default: begin
        if      (req_valid[REQ_MDU]) grant[REQ_MDU] = 1'b1;
        else if (req_valid[REQ_ALU]) grant[REQ_ALU] = 1'b1;
        else if (req_valid[REQ_LSU]) grant[REQ_LSU] = 1'b1;
      end
    endcase
  end

  // A grant is always an accepted transfer, so the pointer moves to the winner's successor.
  always_comb begin
    ptr_nxt = ptr;
    if      (grant[REQ_ALU]) ptr_nxt = 2'd1;
    else if (grant[REQ_LSU]) ptr_nxt = 2'd2;
    else if (grant[REQ_MDU]) ptr_nxt = 2'd0;
  end

  // Pointer register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) ptr <= 2'd0;
    else       ptr <= ptr_nxt;
  end

endmodule

// File: rtl/riscv32ima_wback_ctrl.sv
// GPRF writeback controller: arbitrates ALU/LSU/MDU results onto one write port, tracks pending rd.
// Latency: one cycle from accepted transfer to wback_reg_*; chk_busy and req_ready are combinational.
// Backpressure: one grant per cycle via req_ready; losing requesters hold their result until granted.
module riscv32ima_wback_ctrl
  import riscv32ima_pkg::*;
(
  input  logic                                 clk,
  input  logic                                 nrst,
  input  logic                                 issue_valid,
  input  logic [REG_ADDR_WIDTH-1:0]            issue_rd,
  input  logic [REG_ADDR_WIDTH-1:0]            chk0_addr,
  input  logic [REG_ADDR_WIDTH-1:0]            chk1_addr,
  input  logic [REG_ADDR_WIDTH-1:0]            chk_rd,
  output logic                                 chk_busy,
  input  logic [NUM_WB_REQ-1:0]                req_valid,
  input  logic [NUM_WB_REQ*REG_ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_WB_REQ*REG_DATA_WIDTH-1:0] req_data,
  output logic [NUM_WB_REQ-1:0]                req_ready,
  output logic                                 wback_reg_wen,
  output logic [REG_ADDR_WIDTH-1:0]            wback_reg_addr,
  output logic [REG_DATA_WIDTH-1:0]            wback_reg_data,
  output logic                                 sb_err
);

  logic                      xfer;
  logic [REG_ADDR_WIDTH-1:0] gnt_addr;
  logic [REG_DATA_WIDTH-1:0] gnt_data;
  logic [NUM_REGS-1:0]       pending;
  logic [NUM_REGS-1:0]       set_vec;
  logic [NUM_REGS-1:0]       clr_vec;
  logic [NUM_REGS-1:0]       pending_nxt;

  riscv32ima_rr_arb3 u_arb (
    .clk       (clk),
    .nrst      (nrst),
    .req_valid (req_valid),
    .grant     (req_ready)
  );

  // The arbiter only grants valid requesters, so any grant is a completed transfer.
  assign xfer = |req_ready;

  // Select the granted requester's rd and result.
  always_comb begin
    gnt_addr = '0;
    gnt_data = '0;
    for (int i = 0; i < NUM_WB_REQ; i++) begin
      if (req_ready[i]) begin
        gnt_addr = req_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
        gnt_data = req_data[i*REG_DATA_WIDTH +: REG_DATA_WIDTH];
      end
    end
  end

  // Scoreboard update: clear on the GPRF capture edge, set on issue; set wins, x0 never pending.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue_valid)   set_vec[issue_rd]       = 1'b1;
    if (wback_reg_wen) clr_vec[wback_reg_addr] = 1'b1;
    set_vec[0]  = 1'b0;
    pending_nxt = (pending & ~clr_vec) | set_vec;
  end

  // Output stage: results to x0 are consumed but never produce a write enable.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wback_reg_wen  <= 1'b0;
      wback_reg_addr <= '0;
      wback_reg_data <= '0;
    end else begin
      wback_reg_wen <= xfer && (gnt_addr != '0);
      if (xfer) begin
        wback_reg_addr <= gnt_addr;
        wback_reg_data <= gnt_data;
      end
    end
  end

  // Pending-destination scoreboard register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) pending <= '0;
    else       pending <= pending_nxt;
  end

  // Sticky error: a write landed on a register nobody had issued.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) sb_err <= 1'b0;
    else       sb_err <= sb_err | (wback_reg_wen & ~pending[wback_reg_addr]);
  end

  assign chk_busy = pending[chk0_addr] | pending[chk1_addr] | pending[chk_rd];

endmodule

// File: tb/tb_riscv32ima_wback_ctrl.sv
// Bench for riscv32ima_wback_ctrl: directed vectors, writeback scoreboard checked by a monitor.
// Latency: expected writes are queued at the transfer cycle and popped when wback_reg_wen shows.
// Backpressure: stimulus follows the hold-until-ready rule for every requester.
module tb_riscv32ima_wback_ctrl;
  import riscv32ima_pkg::*;

  localparam int AW = REG_ADDR_WIDTH;
  localparam int DW = REG_DATA_WIDTH;

  logic                  clk = 1'b0;
  logic                  nrst;
  logic                  issue_valid;
  logic [AW-1:0]         issue_rd;
  logic [AW-1:0]         chk0_addr;
  logic [AW-1:0]         chk1_addr;
  logic [AW-1:0]         chk_rd;
  logic                  chk_busy;
  logic [2:0]            req_valid;
  logic [3*AW-1:0]       req_addr;
  logic [3*DW-1:0]       req_data;
  logic [2:0]            req_ready;
  logic                  wback_reg_wen;
  logic [AW-1:0]         wback_reg_addr;
  logic [DW-1:0]         wback_reg_data;
  logic                  sb_err;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        mon_e;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [2:0] exp_g [6];
  int         gcnt  [3];
  logic [DW-1:0] rr_d;

  riscv32ima_wback_ctrl dut (
    .clk            (clk),
    .nrst           (nrst),
    .issue_valid    (issue_valid),
    .issue_rd       (issue_rd),
    .chk0_addr      (chk0_addr),
    .chk1_addr      (chk1_addr),
    .chk_rd         (chk_rd),
    .chk_busy       (chk_busy),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .wback_reg_wen  (wback_reg_wen),
    .wback_reg_addr (wback_reg_addr),
    .wback_reg_data (wback_reg_data),
    .sb_err         (sb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  // Monitor: every GPRF write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (wback_reg_wen === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL wb_unexpected: got write addr %0d data %h, want no write",
                 wback_reg_addr, wback_reg_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wb_addr", 64'(wback_reg_addr), 64'(mon_e.a));
        chk("wb_data", 64'(wback_reg_data), 64'(mon_e.d));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    nrst = 1'b1; issue_valid = 1'b0; issue_rd = '0;
    chk0_addr = 5'd5; chk1_addr = 5'd3; chk_rd = 5'd7;
    req_valid = 3'b000; req_addr = '0; req_data = '0;
    exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100;
    exp_g[3] = 3'b001; exp_g[4] = 3'b010; exp_g[5] = 3'b100;
    for (int i = 0; i < 3; i++) gcnt[i] = 0;

    // Reset asserted mid-cycle with the clock running.
    repeat (2) @(posedge clk);
    #3 nrst = 1'b0;
    #1;
    chk("rst_wen",   64'(wback_reg_wen),  64'd0);
    chk("rst_addr",  64'(wback_reg_addr), 64'd0);
    chk("rst_data",  64'(wback_reg_data), 64'd0);
    chk("rst_sberr", 64'(sb_err),         64'd0);
    chk("rst_ready", 64'(req_ready),      64'd0);
    chk("rst_busy",  64'(chk_busy),       64'd0);
    chk0_addr = '0; chk1_addr = '0; chk_rd = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) nrst = 1'b1;
    step();

    // Single ALU write to x5.
    issue_valid = 1'b1; issue_rd = 5'd5; chk0_addr = 5'd5;
    @(negedge clk) chk("alu_busy_pre", 64'(chk_busy), 64'd0);
    step();
    issue_valid = 1'b0;
    drive_req(REQ_ALU, 5'd5, 32'hDEADBEEF); req_valid = 3'b001;
    @(negedge clk);
    chk("alu_ready", 64'(req_ready), 64'b001);
    chk("alu_busy_issued", 64'(chk_busy), 64'd1);
    exp_q.push_back('{a: 5'd5, d: 32'hDEADBEEF});
    step();
    req_valid = 3'b000;
    @(negedge clk);
    chk("alu_busy_wcycle", 64'(chk_busy), 64'd1);
    chk("alu_wen", 64'(wback_reg_wen), 64'd1);
    step();
    @(negedge clk);
    chk("alu_busy_after", 64'(chk_busy), 64'd0);
    chk("alu_sberr", 64'(sb_err), 64'd0);
    chk("alu_wen_idle", 64'(wback_reg_wen), 64'd0);
    step();
    chk0_addr = '0;

    // MDU result to x0 (consumed, no write) while pre-issuing x1..x3.
    issue_valid = 1'b1; issue_rd = 5'd1;
    drive_req(REQ_MDU, 5'd0, 32'h00000BAD); req_valid = 3'b100;
    @(negedge clk) chk("x0_mdu_ready", 64'(req_ready), 64'b100);
    step();
    req_valid = 3'b000; issue_rd = 5'd2;
    @(negedge clk) chk("x0_mdu_no_wen", 64'(wback_reg_wen), 64'd0);
    step();
    issue_rd = 5'd3;
    step();
    issue_valid = 1'b0;

    // Round-robin contention: each winner drops valid for one cycle, then returns.
    for (int k = 0; k < 6; k++) begin
      req_valid = (k == 0) ? 3'b111 : (3'b111 & ~exp_g[k-1]);
      for (int i = 0; i < 3; i++)
        drive_req(i, AW'(i + 1), {8'(8'hC0 + i), 24'(gcnt[i])});
      // Re-issue the rd being written this cycle so the second round stays legal.
      issue_valid = (k >= 1 && k <= 3);
      issue_rd    = AW'(k);
      @(negedge clk);
      chk("rr_grant", 64'(req_ready), 64'(exp_g[k]));
      if (k > 0) chk("rr_wen_no_gap", 64'(wback_reg_wen), 64'd1);
      for (int i = 0; i < 3; i++) begin
        if (exp_g[k][i]) begin
          rr_d = {8'(8'hC0 + i), 24'(gcnt[i])};
          exp_q.push_back('{a: AW'(i + 1), d: rr_d});
          gcnt[i]++;
        end
      end
      step();
    end
    req_valid = 3'b000; issue_valid = 1'b0;
    @(negedge clk) chk("rr_wen_last", 64'(wback_reg_wen), 64'd1);
    step();
    chk0_addr = 5'd1; chk1_addr = 5'd2; chk_rd = 5'd3;
    @(negedge clk);
    chk("rr_busy_drained", 64'(chk_busy), 64'd0);
    chk("rr_sberr", 64'(sb_err), 64'd0);
    step();

    // Simultaneous set and clear of x7.
    chk0_addr = '0; chk1_addr = '0; chk_rd = 5'd7;
    issue_valid = 1'b1; issue_rd = 5'd7;
    step();
    issue_valid = 1'b0;
    drive_req(REQ_ALU, 5'd7, 32'h77770007); req_valid = 3'b001;
    @(negedge clk) chk("setclr_ready", 64'(req_ready), 64'b001);
    exp_q.push_back('{a: 5'd7, d: 32'h77770007});
    step();
    req_valid = 3'b000; issue_valid = 1'b1; issue_rd = 5'd7;
    @(negedge clk) chk("setclr_busy_wcycle", 64'(chk_busy), 64'd1);
    step();
    issue_valid = 1'b0;
    @(negedge clk);
    chk("setclr_busy_after", 64'(chk_busy), 64'd1);
    chk("setclr_sberr", 64'(sb_err), 64'd0);
    step();
    chk_rd = '0;

    // x0 from ALU, then an LSU write to x9 that was never issued.
    drive_req(REQ_ALU, 5'd0, 32'h00000123); req_valid = 3'b001;
    @(negedge clk) chk("x0_alu_ready", 64'(req_ready), 64'b001);
    step();
    req_valid = 3'b000;
    @(negedge clk) chk("x0_alu_no_wen", 64'(wback_reg_wen), 64'd0);
    step();
    drive_req(REQ_LSU, 5'd9, 32'h99990009); req_valid = 3'b010;
    @(negedge clk) chk("err_lsu_ready", 64'(req_ready), 64'b010);
    exp_q.push_back('{a: 5'd9, d: 32'h99990009});
    step();
    req_valid = 3'b000;
    @(negedge clk) chk("err_sberr_wcycle", 64'(sb_err), 64'd0);
    step();
    @(negedge clk) chk("err_sberr_set", 64'(sb_err), 64'd1);
    step(); step();
    @(negedge clk) chk("err_sberr_sticky", 64'(sb_err), 64'd1);
    step();

    // Reset while an MDU write is granted but not yet taken.
    issue_valid = 1'b1; issue_rd = 5'd3;
    step();
    issue_rd = 5'd4;
    step();
    issue_valid = 1'b0;
    chk0_addr = 5'd3; chk1_addr = 5'd4;
    drive_req(REQ_MDU, 5'd3, 32'h33330003); req_valid = 3'b100;
    @(negedge clk);
    chk("rst2_mdu_ready", 64'(req_ready), 64'b100);
    chk("rst2_busy_pre", 64'(chk_busy), 64'd1);
    #2 nrst = 1'b0;
    #1;
    chk("rst2_wen", 64'(wback_reg_wen), 64'd0);
    chk("rst2_busy", 64'(chk_busy), 64'd0);
    chk("rst2_sberr", 64'(sb_err), 64'd0);
    drive_req(REQ_ALU, 5'd0, 32'h0); drive_req(REQ_MDU, 5'd0, 32'h0);
    req_valid = 3'b101;
    @(posedge clk);
    @(negedge clk) nrst = 1'b1;
    #1 chk("rst2_ptr_zero", 64'(req_ready), 64'b001);
    drive_req(REQ_LSU, 5'd4, 32'h44440004); req_valid = 3'b010;
    issue_valid = 1'b1; issue_rd = 5'd4;
    #1 chk("rst2_lsu_ready", 64'(req_ready), 64'b010);
    exp_q.push_back('{a: 5'd4, d: 32'h44440004});
    step();
    req_valid = 3'b000; issue_valid = 1'b0;
    step();
    @(negedge clk);
    chk("rst2_sberr_after", 64'(sb_err), 64'd0);
    chk("rst2_busy_after", 64'(chk_busy), 64'd0);
    step();

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/riscv32ima_wback_ctrl.md
Name: riscv32ima_wback_ctrl

Overview:
- Writeback controller for the 32-entry GPRF, which has one write port.
- Shares that port round-robin between three result producers: ALU, load/store unit (LSU) and mul/div unit (MDU).
- Keeps a pending-destination scoreboard so decode can stall on RAW/WAW hazards against in-flight results.
- Sits between the execute-stage units and the GPRF wback_reg_* port; decode drives the issue and check ports.

Parameters:
- REG_ADDR_WIDTH, 5, GPRF register index width.
- REG_DATA_WIDTH, 32, GPRF data width.

Ports:
- clk  input  1  clock; all state updates on posedge.
- nrst  input  1  reset, asynchronous, active-low.
- issue_valid  input  1  decode issues an instruction that writes issue_rd.
- issue_rd  input  REG_ADDR_WIDTH  destination of the issued instruction.
- chk0_addr  input  REG_ADDR_WIDTH  rs1 of the instruction in decode.
- chk1_addr  input  REG_ADDR_WIDTH  rs2 of the instruction in decode.
- chk_rd  input  REG_ADDR_WIDTH  rd of the instruction in decode.
- chk_busy  output  1  any of chk0/chk1/chk_rd is pending; combinational.
- req_valid  input  3  per-requester result valid; bit 0 ALU, bit 1 LSU, bit 2 MDU.
- req_addr  input  3*REG_ADDR_WIDTH  per-requester rd; requester i uses slice i.
- req_data  input  3*REG_DATA_WIDTH  per-requester result; requester i uses slice i.
- req_ready  output  3  one-hot grant; combinational.
- wback_reg_wen  output  1  GPRF write enable; registered.
- wback_reg_addr  output  REG_ADDR_WIDTH  GPRF write index; registered.
- wback_reg_data  output  REG_DATA_WIDTH  GPRF write data; registered.
- sb_err  output  1  sticky flag: writeback to a non-pending register.

Behaviour:
- Reset (nrst low, asynchronous):
  - wback_reg_wen/addr/data = 0, sb_err = 0.
  - Round-robin pointer = 0; pending[31:1] = 0.
  - Reset mid-operation drops any in-flight granted write.
  - A requester holding valid across reset is re-arbitrated normally after release.
- Arbitration (combinational):
  - Grant the first valid requester at or after the pointer, scanning 0→1→2 with wrap.
  - req_ready = one-hot grant, or 0 if no requester is valid.
  - A transfer completes when req_valid[i] and req_ready[i] are both high at a posedge.
  - A requester must hold valid/addr/data stable until it sees ready; ready never depends on a later cycle.
- Pointer:
  - On any transfer from requester g, pointer <= (g+1) mod 3.
  - Otherwise the pointer holds.
  - Fairness consequence: no valid requester waits more than 2 grants.
- Output stage:
  - One-cycle latency: a transfer at edge N drives wback_* during cycle N..N+1, and the GPRF captures it at edge N+1.
  - wback_reg_wen <= transfer && granted addr != 0.
  - addr/data are registered from the granted slice every cycle a transfer occurs.
  - With no transfer: wen <= 0, addr/data hold.
  - An addr-0 result is consumed (ready asserted) but never written.
- Scoreboard (pending[r], r = 1..31; r = 0 is never pending):
  - Set at a posedge when issue_valid && issue_rd == r.
  - Clear at a posedge when wback_reg_wen && wback_reg_addr == r, i.e. at the edge on which the GPRF captures the data.
  - chk_busy therefore stays high through the write cycle, because the GPRF read still returns the old value then.
  - Simultaneous set and clear of the same r: set wins (new producer in flight).
  - Issue to an already-pending r (WAW): pending stays 1. Decode must not issue such an instruction; it stalls on chk_busy via chk_rd.
  - chk_busy = pending[chk0_addr] | pending[chk1_addr] | pending[chk_rd]. Index 0 always reads 0.
- Error:
  - sb_err <= 1 when wback_reg_wen && !pending[wback_reg_addr], evaluated with the pre-edge value.
  - Sticky until reset.

Decomposition:
- Shared package riscv32ima_pkg:
  - REG_ADDR_WIDTH and REG_DATA_WIDTH constants.
  - Requester index constants REQ_ALU = 0, REQ_LSU = 1, REQ_MDU = 2.
  - NUM_WB_REQ = 3.
- Sub-module riscv32ima_rr_arb3:
  - Inputs: req_valid[2:0], clk, nrst.
  - Outputs: one-hot grant; owns the pointer and advances it on accept.
  - Reusable for the memory-port arbiter.
- Scoreboard and output register stay in the top module.

Test Plan:
- Reset then idle:
  - Stimulus: nrst low mid-cycle with clk running.
  - Required: all outputs 0 immediately; req_ready = 0 while req_valid = 0.
- Single ALU write:
  - Stimulus: issue rd=5; next cycle req_valid = 001, addr 5, data 0xDEADBEEF.
  - Required: req_ready = 001 that cycle; next cycle wen = 1, addr 5, data 0xDEADBEEF.
  - Required: chk0=5 gives chk_busy = 1 through the write cycle and 0 the cycle after; sb_err = 0.
- Round-robin contention:
  - Stimulus: all three valid continuously with rd 1/2/3, each dropping valid after its grant and reasserting.
  - Required: grant order ALU, LSU, MDU, ALU, ...; no gaps in wen.
- Simultaneous set/clear:
  - Stimulus: issue rd=7 in the cycle wback writes 7.
  - Required: pending[7] = 1 afterwards; chk_busy = 1 for chk_rd=7.
- x0 and error:
  - Stimulus: ALU result to addr 0; later an LSU result to addr 9 never issued.
  - Required: addr 0 is accepted with wen = 0; addr 9 gives wen = 1 and sb_err = 1 sticky.
- Reset mid-operation:
  - Stimulus: pending{3,4}, MDU granted, then nrst pulse.
  - Required: pending cleared, wen = 0, pointer = 0; the next request from LSU alone is granted.
